// File: rtl/axil_subordinate_regs.sv
// AXI4-Lite subordinate register file: NUM_REGS x 32-bit words, mirrored flat on REG_OUT.
// Optional macro AXIL_SUB_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axil_subordinate_regs #(
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [32*NUM_REGS-1:0]        REG_OUT
);
  localparam int IDX_W     = C_S_AXI_ADDR_WIDTH - 2;
  localparam int REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [0:0] WR_IDLE = 1'b0;
  localparam logic [0:0] WR_RESP = 1'b1;
  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_DATA = 1'b1;

  logic [31:0]      r_regs [NUM_REGS];
  logic             r_started;
  logic [0:0]       r_wr_state;
  logic [0:0]       r_rd_state;
  logic             r_awready;
  logic             r_wready;
  logic             r_aw_held;
  logic             r_w_held;
  logic [IDX_W-1:0] r_aw_idx;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wstrb;
  logic             r_bvalid;
  logic [1:0]       r_bresp;
  logic             r_arready;
  logic             r_rvalid;
  logic [31:0]      r_rdata;
  logic [1:0]       r_rresp;

  logic [31:0] w_aw_idx_ext;
  logic [31:0] w_ar_idx_ext;
  logic        w_aw_in_range;
  logic        w_ar_in_range;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_ar_hs;
  logic        w_commit;
  logic [1:0]  w_aw_resp;
  logic [1:0]  w_ar_resp;
  logic [31:0] w_wmask;
  logic [31:0] w_rd_word;
  logic        w_unused;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Range checks are done at 32 bits so a fully populated map still compiles cleanly.
  assign w_aw_idx_ext  = 32'(r_aw_idx);
  assign w_ar_idx_ext  = 32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
  assign w_aw_in_range = (w_aw_idx_ext < NUM_REGS);
  assign w_ar_in_range = (w_ar_idx_ext < NUM_REGS);

  assign w_aw_hs  = S_AXI_AWVALID && r_awready;
  assign w_w_hs   = S_AXI_WVALID && r_wready;
  assign w_ar_hs  = S_AXI_ARVALID && r_arready;
  assign w_commit = (r_wr_state == WR_IDLE) && r_aw_held && r_w_held;

`ifdef AXIL_SUB_SLVERR_EN
  assign w_aw_resp = w_aw_in_range ? 2'b00 : 2'b10;
  assign w_ar_resp = w_ar_in_range ? 2'b00 : 2'b10;
`else
  assign w_aw_resp = 2'b00;
  assign w_ar_resp = 2'b00;
`endif

  assign w_rd_word = w_ar_in_range ? r_regs[w_ar_idx_ext[REG_IDX_W-1:0]] : 32'h0;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wmask
      assign w_wmask[8*gi +: 8] = {8{r_wstrb[gi]}};
    end
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
      assign REG_OUT[32*gi +: 32] = r_regs[gi];
    end
  endgenerate

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= 32'h0;
    end else if (w_commit && w_aw_in_range) begin
      r_regs[w_aw_idx_ext[REG_IDX_W-1:0]] <=
        (r_regs[w_aw_idx_ext[REG_IDX_W-1:0]] & ~w_wmask) | (r_wdata & w_wmask);
    end
  end

  // AW and W are latched independently; the commit waits for both.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_started  <= 1'b0;
      r_wr_state <= WR_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_aw_idx   <= '0;
      r_wdata    <= 32'h0;
      r_wstrb    <= 4'h0;
      r_bvalid   <= 1'b0;
      r_bresp    <= 2'b00;
    end else begin
      if (!r_started) begin
        r_started <= 1'b1;
        r_awready <= 1'b1;
        r_wready  <= 1'b1;
      end
      if (w_aw_hs) begin
        r_aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        r_aw_held <= 1'b1;
        r_awready <= 1'b0;
      end
      if (w_w_hs) begin
        r_wdata  <= S_AXI_WDATA;
        r_wstrb  <= S_AXI_WSTRB;
        r_w_held <= 1'b1;
        r_wready <= 1'b0;
      end
      case (r_wr_state)
        WR_IDLE: begin
          if (w_commit) begin
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_bvalid   <= 1'b1;
            r_bresp    <= w_aw_resp;
            r_wr_state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (r_bvalid && S_AXI_BREADY) begin
            r_bvalid   <= 1'b0;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_wr_state <= WR_IDLE;
          end
        end
        default: r_wr_state <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rd_state <= RD_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= 32'h0;
      r_rresp    <= 2'b00;
    end else begin
      if (!r_started) r_arready <= 1'b1;
      case (r_rd_state)
        RD_IDLE: begin
          if (w_ar_hs) begin
            r_arready  <= 1'b0;
            r_rdata    <= w_rd_word;
            r_rresp    <= w_ar_resp;
            r_rvalid   <= 1'b1;
            r_rd_state <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (S_AXI_RREADY) begin
            r_rvalid   <= 1'b0;
            r_arready  <= 1'b1;
            r_rd_state <= RD_IDLE;
          end
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
endmodule

// File: tb/tb_axil_subordinate_regs.sv
// Bench for axil_subordinate_regs: table vectors, corner-case sequences and random traffic vs a word-array model.
module tb_axil_subordinate_regs;
  localparam int AW = 7;
  localparam int NR = 16;
`ifdef AXIL_SUB_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic [32*NR-1:0] reg_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model [NR];

  typedef struct {
    bit          is_wr;
    logic [6:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t vecs [10];

  always #5 clk = ~clk;

  axil_subordinate_regs #(.C_S_AXI_ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .REG_OUT(reg_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string name);
    logic [32*NR-1:0] exp;
    for (int k = 0; k < NR; k++) exp[32*k +: 32] = model[k];
    n_checks++;
    if (reg_out !== exp) begin
      n_errors++;
      $display("FAIL %s: REG_OUT got %h expected %h", name, reg_out, exp);
    end
  endtask

  function automatic int word_of(input logic [6:0] a);
    return int'(a[6:2]);
  endfunction

  task automatic model_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s);
    int w;
    w = word_of(a);
    if (w < NR)
      for (int b = 0; b < 4; b++)
        if (s[b]) model[w][8*b +: 8] = d[8*b +: 8];
  endtask

  function automatic logic [31:0] model_read(input logic [6:0] a);
    return (word_of(a) < NR) ? model[word_of(a)] : 32'h0;
  endfunction

  function automatic logic [1:0] model_resp(input logic [6:0] a);
    return (word_of(a) < NR) ? 2'b00 : OOR_RESP;
  endfunction

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timeout waiting for handshake", name);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    int n;
    bit hs_aw, hs_w;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 50) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(posedge clk); #1; n++;
      if (hs_aw) awvalid = 1'b0;
      if (hs_w)  wvalid  = 1'b0;
    end
    while (!bvalid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bvalid) begin
      timeout_fail("write");
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; resp = 2'bxx;
      return;
    end
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [6:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!arready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    while (!rvalid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!rvalid) begin
      timeout_fail("read");
      d = 32'hx; resp = 2'bxx;
      return;
    end
    d = rdata; resp = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] d, held;
    logic [6:0]  a;
    logic [3:0]  s;
    bit          bad;

    vecs[0] = '{1'b1, 7'h08, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00};
    vecs[1] = '{1'b0, 7'h08, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00};
    vecs[2] = '{1'b1, 7'h00, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b00};
    vecs[3] = '{1'b1, 7'h00, 32'h00000000, 4'h5, 32'h0,        2'b00};
    vecs[4] = '{1'b0, 7'h00, 32'h0,        4'h0, 32'hFF00FF00, 2'b00};
    vecs[5] = '{1'b0, 7'h0B, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00};
    vecs[6] = '{1'b1, 7'h40, 32'h12345678, 4'hF, 32'h0,        OOR_RESP};
    vecs[7] = '{1'b0, 7'h40, 32'h0,        4'h0, 32'h00000000, OOR_RESP};
    vecs[8] = '{1'b1, 7'h3C, 32'hA5A5A5A5, 4'hC, 32'h0,        2'b00};
    vecs[9] = '{1'b0, 7'h3E, 32'h0,        4'h0, 32'hA5A50000, 2'b00};

    for (int k = 0; k < NR; k++) model[k] = 32'h0;
    rst_n = 1'b0;
    awaddr = '0; araddr = '0; awprot = 3'b0; arprot = 3'b0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_awready", {31'b0, awready}, 32'd0);
    chk("rst_arready", {31'b0, arready}, 32'd0);
    chk("rst_bvalid",  {31'b0, bvalid},  32'd0);
    chk("rst_rvalid",  {31'b0, rvalid},  32'd0);
    chk("rst_rdata",   rdata, 32'h0);
    chk_regs("rst_regs");
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", {29'b0, awready, wready, arready}, 32'h7);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
        $display("vec %0d: write addr=%h data=%h strb=%h bresp=%b", i, vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        chk($sformatf("vec%0d_bresp", i), {30'b0, resp}, {30'b0, vecs[i].exp_resp});
        chk_regs($sformatf("vec%0d_regs", i));
      end else begin
        do_read(vecs[i].addr, d, resp);
        $display("vec %0d: read addr=%h rdata=%h rresp=%b", i, vecs[i].addr, d, resp);
        chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
        chk($sformatf("vec%0d_rresp", i), {30'b0, resp}, {30'b0, vecs[i].exp_resp});
      end
    end

    // W three cycles ahead of AW
    wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    chk("wfirst_wready_low", {31'b0, wready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("wfirst_no_early_b", {31'b0, bvalid}, 32'd0);
    awaddr = 7'h04; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("wfirst_b_not_yet", {31'b0, bvalid}, 32'd0);
    @(posedge clk); #1;
    model_write(7'h04, 32'h11223344, 4'hF);
    chk("wfirst_bvalid", {31'b0, bvalid}, 32'd1);
    chk_regs("wfirst_regs");
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("wfirst_after_b", {29'b0, bvalid, awready, wready}, 32'h3);
    $display("seq: W-before-AW write word1=%h", reg_out[63:32]);

    // Write commit and AR to the same word on one edge: read sees the old value
    awaddr = 7'h08; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 7'h08; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("collide_rdata_old", rdata, model[2]);
    model_write(7'h08, 32'hCAFEF00D, 4'hF);
    chk_regs("collide_regs");
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    do_read(7'h08, d, resp);
    chk("collide_rdata_new", d, 32'hCAFEF00D);
    $display("seq: collide read new=%h", d);

    // Backpressure on B and R for 10 cycles
    awaddr = 7'h0C; wdata = 32'h5A5A0F0F; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 7'h00; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    held = rdata;
    chk("bp_rdata", held, model[0]);
    model_write(7'h0C, 32'h5A5A0F0F, 4'hF);
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (!bvalid || !rvalid || awready || wready || arready || rdata !== held) bad = 1'b1;
    end
    chk("bp_hold", {31'b0, bad}, 32'd0);
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    chk("bp_release", {27'b0, bvalid, rvalid, awready, wready, arready}, 32'h7);
    chk_regs("bp_regs");
    $display("seq: backpressure held rdata=%h", held);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      a = 7'($urandom_range(0, 79));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        do_write(a, d, s, resp);
        model_write(a, d, s);
        $display("rnd %0d: write addr=%h data=%h strb=%h bresp=%b", i, a, d, s, resp);
        chk("rnd_bresp", {30'b0, resp}, {30'b0, model_resp(a)});
        chk_regs("rnd_regs");
      end else begin
        do_read(a, d, resp);
        $display("rnd %0d: read addr=%h rdata=%h rresp=%b", i, a, d, resp);
        chk("rnd_rdata", d, model_read(a));
        chk("rnd_rresp", {30'b0, resp}, {30'b0, model_resp(a)});
      end
    end

    // Reset while a B beat and an R beat are pending
    awaddr = 7'h10; wdata = 32'h87654321; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    araddr = 7'h10; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("rstmid_pending", {30'b0, bvalid, rvalid}, 32'h3);
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NR; k++) model[k] = 32'h0;
    chk("rstmid_valids", {30'b0, bvalid, rvalid}, 32'h0);
    chk_regs("rstmid_regs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bvalid || rvalid) bad = 1'b1;
    end
    chk("rstmid_no_stray", {31'b0, bad}, 32'd0);
    chk("rstmid_ready", {29'b0, awready, wready, arready}, 32'h7);
    do_write(7'h14, 32'h0BADF00D, 4'hF, resp);
    model_write(7'h14, 32'h0BADF00D, 4'hF);
    do_read(7'h14, d, resp);
    chk("rstmid_recover", d, 32'h0BADF00D);
    chk_regs("rstmid_recover_regs");
    $display("seq: reset mid-transaction, recovered read=%h", d);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
